// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and widths for the IF/MEM unified-memory port arbiter.
//   arb_state_t : arbiter FSM states
//   gnt_t       : grant source decided in IDLE
//   LAT_CNT_W   : width of the access latency counter
//   STARVE_CNT_W: width of the fetch anti-starvation counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int LAT_CNT_W    = 4;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
// Saturating counter of data grants made while a fetch is waiting.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one data grant (ignored once saturated)
//   clr      : clear to zero (wins over inc)
//   at_max   : count has reached STARVE_MAX, fetch must win the next conflict
// -----------------------------------------------------------------------------
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [STARVE_CNT_W-1:0] cnt;

    assign at_max = (cnt == STARVE_CNT_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port fixed-latency memory between instruction fetch (IF)
// and the MEM-stage data port. Data has priority; fetch is guaranteed a grant
// after STARVE_MAX consecutive data grants taken while it was waiting.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (level) and byte address
//   if_rdata/if_valid             fetched word and one-cycle done pulse
//   d_req/d_we/d_addr/d_wdata     data request (level), store flag, address, data
//   d_rdata/d_valid               load data and one-cycle done pulse
//   stall_if/stall_mem            combinational pipeline stalls
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata           memory interface, rdata valid MEM_LAT after en
//
// Optional build macro MEM_ARB_PERF_EN adds perf_if_grants, perf_d_grants and
// perf_conflicts (32-bit wrapping event counters).
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts
`endif
);

    arb_state_t           state_q, state_d;
    gnt_t                 gnt;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 acc_we;      // outstanding data access is a store
    logic                 busy;
    logic                 arb_en;
    logic                 done;
    logic                 starve_max;

    assign busy = (state_q != IDLE);

    // The valid-pulse cycle is the idle gap between accesses. The requester
    // that just finished still holds its old request there, so nobody is
    // arbitrated in that cycle; fresh requests are seen one cycle later.
    assign arb_en = !busy && !if_valid && !d_valid;

    // lat_cnt is held during the strobe cycle, so reaching 1 afterwards lines
    // up exactly with the cycle in which mem_rdata is valid.
    assign done = busy && !mem_en && (lat_cnt == LAT_CNT_W'(1));

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req  & ~d_valid;

    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc   ((gnt == GNT_D) && if_req),
        .clr   ((gnt == GNT_IF) || (!busy && !if_req)),
        .at_max(starve_max)
    );

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt = GNT_NONE;
        if (arb_en) begin
            if (d_req && (!if_req || !starve_max)) begin
                gnt = GNT_D;
            end else if (if_req) begin
                gnt = GNT_IF;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt == GNT_IF) begin
                    state_d = BUSY_I;
                end else if (gnt == GNT_D) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt   <= '0;
            acc_we    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state_q  <= state_d;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            case (gnt)
                GNT_IF: begin
                    mem_en   <= 1'b1;
                    mem_addr <= if_addr;
                    acc_we   <= 1'b0;
                end
                GNT_D: begin
                    mem_en    <= 1'b1;
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    acc_we    <= d_we;
                end
                default: ;
            endcase

            if (gnt != GNT_NONE) begin
                lat_cnt <= LAT_CNT_W'(MEM_LAT);
            end else if (busy && !mem_en && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (done) begin
                if (state_q == BUSY_I) begin
                    if_valid <= 1'b1;
                    if_rdata <= if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                end else begin
                    d_valid <= 1'b1;
                    if (!acc_we) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_grants <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else begin
            if (gnt == GNT_IF) perf_if_grants <= perf_if_grants + 1'b1;
            if (gnt == GNT_D)  perf_d_grants  <= perf_d_grants + 1'b1;
            if (arb_en && if_req && d_req) perf_conflicts <= perf_conflicts + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Bench for mem_port_arbiter with a behavioural MEM_LAT-deep memory. Directed
// vector table, multi-cycle corner sequences, then randomized traffic against
// a transaction-timeline reference model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, d_req, d_we;
    logic [ADDR_W-1:0] if_addr, d_addr, mem_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic [31:0]       if_rdata;
    logic              if_valid, d_valid, stall_if, stall_mem, mem_en, mem_we;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_if_grants, perf_d_grants, perf_conflicts;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    // Known contents per doubleword index; index 0x20 (byte 0x100) is special.
    function automatic logic [63:0] mem_init(input int i);
        logic [31:0] hi, lo;
        if (i == 32) return 64'hAAAA_BBBB_1111_2222;
        hi = 32'hC0DE_0000 | 32'(i);
        lo = 32'h0000_F000 + 32'(i * 3);
        return {hi, lo};
    endfunction

    // Memory model: reloaded during reset, read data appears MEM_LAT cycles
    // after the strobe; other cycles carry noise so mistimed capture shows up.
    logic [63:0] mem     [0:255];
    logic [63:0] rd_pipe [0:MEM_LAT-1];
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
        end else if (mem_en && mem_we) begin
            mem[mem_addr[10:3]] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[10:3]] : {$urandom, $urandom};
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want completion", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ifr, dr, we;
        logic [63:0] ia, da, wd;
        logic        first_if;   // port expected to be granted first
        logic        exp_we;
        logic [63:0] exp_addr;
        logic [63:0] exp_data;   // if_rdata or d_rdata at the first valid
    } vec_t;

    function automatic vec_t mk(input logic ifr, dr, we, input logic [63:0] ia, da, wd,
                                input logic first_if, exp_we,
                                input logic [63:0] exp_addr, exp_data);
        vec_t v;
        v.ifr = ifr; v.dr = dr; v.we = we; v.ia = ia; v.da = da; v.wd = wd;
        v.first_if = first_if; v.exp_we = exp_we;
        v.exp_addr = exp_addr; v.exp_data = exp_data;
        return v;
    endfunction

    // reference model state for the random phase
    logic [63:0] shadow [0:255];

    initial begin
        vec_t        vecs [6];
        int          n, sc, m, ng;
        logic        seen, got_valid;
        logic        gnt_if_q [10];

        vecs[0] = mk(1, 0, 0, 64'h104, 64'h0,   64'h0,    1, 0, 64'h104, 64'hAAAA_BBBB);
        vecs[1] = mk(1, 0, 0, 64'h100, 64'h0,   64'h0,    1, 0, 64'h100, 64'h1111_2222);
        vecs[2] = mk(0, 1, 0, 64'h0,   64'h108, 64'h0,    0, 0, 64'h108, mem_init(33));
        vecs[3] = mk(0, 1, 1, 64'h0,   64'h40,  64'h1234, 0, 1, 64'h40,  64'h0);
        vecs[4] = mk(1, 1, 0, 64'h104, 64'h110, 64'h0,    0, 0, 64'h110, mem_init(34));
        vecs[5] = mk(1, 1, 1, 64'h104, 64'h118, 64'h55,   0, 1, 64'h118, 64'h0);

        // ---------------- reset state ----------------
        do_reset();
        #1;
        check("rst_mem_en",    mem_en,    0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_valid",  if_valid,  0);
        check("rst_d_valid",   d_valid,   0);
        check("rst_if_rdata",  if_rdata,  0);
        check("rst_d_rdata",   d_rdata,   0);
        check("rst_state",     64'(dut.state_q), 64'(IDLE));
        check("rst_lat_cnt",   64'(dut.lat_cnt), 0);

        // ---------------- single-shot vector table ----------------
        for (int i = 0; i < 6; i++) begin
            do_reset();
            if_req = vecs[i].ifr; if_addr = vecs[i].ia;
            d_req = vecs[i].dr; d_we = vecs[i].we; d_addr = vecs[i].da; d_wdata = vecs[i].wd;
            #1;
            sc = (vecs[i].first_if ? stall_if : stall_mem) ? 1 : 0;
            tick();
            check($sformatf("v%0d_mem_en", i),   mem_en,   1);
            check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_mem_we", i),   mem_we,   vecs[i].exp_we);
            if (vecs[i].exp_we) check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wd);
            n = 1;
            while (!(vecs[i].first_if ? if_valid : d_valid) && n < 20) begin
                if (vecs[i].first_if ? stall_if : stall_mem) sc++;
                tick();
                n++;
            end
            check($sformatf("v%0d_latency", i), 64'(n), 64'(MEM_LAT + 2));
            check($sformatf("v%0d_stall_cycles", i), 64'(sc), 64'(MEM_LAT + 2));
            if (vecs[i].first_if)
                check($sformatf("v%0d_rdata", i), 64'(if_rdata), vecs[i].exp_data);
            else
                check($sformatf("v%0d_rdata", i), d_rdata, vecs[i].exp_data);
            if_req = 1'b0; d_req = 1'b0;
            tick();
        end

        // ---------------- store then load to 0x40 ----------------
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h40; d_wdata = 64'h1234;
        m = 0; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (mem_we) m++;
            if (d_valid) seen = 1'b1;
        end
        if (!seen) timeout("st_valid");
        check("st_we_cycles", 64'(m), 1);
        check("st_rdata_kept", d_rdata, 0);
        tick();
        d_we = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (d_valid) seen = 1'b1;
        end
        if (!seen) timeout("ld_valid");
        check("ld_after_st", d_rdata, 64'h1234);
        tick();
        d_req = 1'b0;

        // ---------------- simultaneous: fetch follows data ----------------
        do_reset();
        if_req = 1'b1; if_addr = 64'h104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h110;
        seen = 1'b0; got_valid = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (if_valid) got_valid = 1'b1;
            if (d_valid) seen = 1'b1;
        end
        if (!seen) timeout("sim_d_valid");
        check("sim_if_not_first", got_valid, 0);
        m = 0; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            m++;
            if (k == 0) d_req = 1'b0;
            if (if_valid) seen = 1'b1;
        end
        if (!seen) timeout("sim_if_valid");
        // valid cycle is the idle gap, then the fetch takes MEM_LAT+2
        check("sim_if_after_d", 64'(m), 64'(MEM_LAT + 3));
        check("sim_if_rdata", 64'(if_rdata), 64'hAAAA_BBBB);
        tick();
        if_req = 1'b0;

        // ---------------- starvation bound ----------------
        do_reset();
        if_req = 1'b1; if_addr = 64'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
        ng = 0;
        for (int k = 0; k < 300 && ng < 10; k++) begin
            tick();
            if (mem_en) begin
                gnt_if_q[ng] = (mem_addr == 64'h200);
                if (ng == 3) check("starve_cnt_at_4", 64'(dut.u_starve.cnt), 64'(STARVE_MAX));
                if (ng == 4) check("starve_cnt_clr", 64'(dut.u_starve.cnt), 0);
                ng++;
            end
        end
        if (ng < 10) timeout("starve_grants");
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (if_valid) seen = 1'b1;
        end
        if (!seen) timeout("starve_last_valid");
        tick();
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < ng; i++)
            check($sformatf("starve_gnt%0d_is_if", i), gnt_if_q[i], (i % 5) == 4);
        tick();
        tick();
`ifdef MEM_ARB_PERF_EN
        check("perf_d_grants",  perf_d_grants,  8);
        check("perf_if_grants", perf_if_grants, 2);
        check("perf_conflicts", perf_conflicts, 10);
`endif

        // ---------------- reset during BUSY_D with lat_cnt == 1 ----------------
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h308;
        tick();
        tick();
        tick();
        check("rmid_state_busy", 64'(dut.state_q), 64'(BUSY_D));
        check("rmid_lat_1", 64'(dut.lat_cnt), 1);
        rst = 1'b1;
        tick();
        check("rmid_no_valid", d_valid, 0);
        check("rmid_mem_en", mem_en, 0);
        check("rmid_state_idle", 64'(dut.state_q), 64'(IDLE));
        rst = 1'b0; d_req = 1'b0;
        m = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (d_valid) m++;
        end
        check("rmid_no_late_valid", 64'(m), 0);
        d_req = 1'b1; d_addr = 64'h308;
        n = 0; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            n++;
            if (d_valid) seen = 1'b1;
        end
        if (!seen) timeout("rmid_retry");
        check("rmid_retry_latency", 64'(n), 64'(MEM_LAT + 2));
        check("rmid_retry_data", d_rdata, mem_init(97));
        tick();
        d_req = 1'b0;

        // ---------------- randomized traffic vs timeline model ----------------
        begin
            int          vcyc, gcyc, starve, g;
            logic        cur_if, exp_mwe, exp_ifv, exp_dv, if_pend, d_pend;
            logic [63:0] exp_maddr, exp_mwd, resp, exp_dr, w;
            logic [31:0] exp_ir;
            logic [7:0]  idx;

            do_reset();
            for (int i = 0; i < 256; i++) shadow[i] = mem_init(i);
            vcyc = -1; gcyc = -10; starve = 0; cur_if = 1'b0;
            exp_mwe = 1'b0; exp_maddr = '0; exp_mwd = '0; resp = '0;
            exp_dr = '0; exp_ir = '0; if_pend = 1'b0; d_pend = 1'b0;

            for (int t = 0; t < 1500; t++) begin
                tick();
                if (t == vcyc) begin
                    if (cur_if) exp_ir = resp[31:0];
                    else        exp_dr = resp;
                end
                exp_ifv = (t == vcyc) && cur_if;
                exp_dv  = (t == vcyc) && !cur_if;
                check("rnd_if_valid", if_valid, exp_ifv);
                check("rnd_d_valid",  d_valid,  exp_dv);
                check("rnd_if_rdata", 64'(if_rdata), 64'(exp_ir));
                check("rnd_d_rdata",  d_rdata,  exp_dr);
                check("rnd_mem_en",   mem_en,   t == gcyc + 1);
                check("rnd_mem_we",   mem_we,   (t == gcyc + 1) && exp_mwe);
                if (t == gcyc + 1) begin
                    check("rnd_mem_addr", mem_addr, exp_maddr);
                    if (exp_mwe) check("rnd_mem_wdata", mem_wdata, exp_mwd);
                end

                // requesters: hold through the valid cycle, free the cycle after
                if (t == vcyc + 1) begin
                    if (cur_if) if_pend = 1'b0;
                    else        d_pend  = 1'b0;
                end
                if (!if_pend && $urandom_range(0, 3) != 0) begin
                    if_pend = 1'b1;
                    if_addr = 64'($urandom_range(0, 31)) << 2;
                end
                if (!d_pend && $urandom_range(0, 3) != 0) begin
                    d_pend  = 1'b1;
                    d_we    = 1'($urandom_range(0, 1));
                    d_addr  = 64'($urandom_range(0, 15)) << 3;
                    d_wdata = {$urandom, $urandom};
                end
                if_req = if_pend;
                d_req  = d_pend;
                #1;
                check("rnd_stall_if",  stall_if,  if_req & ~exp_ifv);
                check("rnd_stall_mem", stall_mem, d_req & ~exp_dv);

                // arbiter is idle from the valid cycle on; grants only after it
                if (t >= vcyc && !if_req) starve = 0;
                if (t > vcyc) begin
                    g = 0;
                    if (d_req && (!if_req || starve < STARVE_MAX)) g = 2;
                    else if (if_req) g = 1;
                    if (g == 2) begin
                        if (if_req && starve < STARVE_MAX) starve++;
                        cur_if = 1'b0; exp_maddr = d_addr; exp_mwe = d_we; exp_mwd = d_wdata;
                        idx = d_addr[10:3];
                        if (d_we) begin
                            shadow[idx] = d_wdata;
                            resp = exp_dr;
                        end else begin
                            resp = shadow[idx];
                        end
                    end
                    if (g == 1) begin
                        starve = 0;
                        cur_if = 1'b1; exp_maddr = if_addr; exp_mwe = 1'b0;
                        w = shadow[if_addr[10:3]];
                        resp = if_addr[2] ? {32'h0, w[63:32]} : {32'h0, w[31:0]};
                    end
                    if (g != 0) begin
                        gcyc = t;
                        vcyc = t + MEM_LAT + 2;
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
